// File: rtl/ncl_seg_capture.sv
// ncl_seg_capture: clocked sink for a dual-rail NCL 7-segment wavefront.
// Synchronizes seg_t/seg_f, waits for a stable complete DATA or NULL
// wavefront, latches DATA as single-rail seg_out and drives the NCL ack.
//
// Handshake (four-phase NCL): ko=1 requests DATA from upstream and ko=0
// requests NULL. ko toggles only when the requested wavefront has been seen
// complete and stable. seg_valid is a one-cycle pulse with no back-pressure:
// seg_out is meaningful on, and holds after, every cycle seg_valid is high.
module ncl_seg_capture #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT       = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_t,
  input  logic [6:0]       seg_f,
  output logic             ko,
  output logic [6:0]       seg_out,
  output logic             seg_valid,
  output logic [CNT_W-1:0] wave_count,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic             dbg_state
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    WAIT_NULL = 1'b0,
    WAIT_DATA = 1'b1
  } state_e;

  // Synchronizer chains, one flop column per stage.
  logic [SYNC_STAGES-1:0][6:0] st_sync_q;
  logic [SYNC_STAGES-1:0][6:0] sf_sync_q;
  // Fill marker: the chains are not trusted until refilled after reset.
  logic [SYNC_STAGES-1:0]      fill_q;

  logic [6:0]       st;
  logic [6:0]       sf;
  logic             sync_ok;
  logic [6:0]       prev_st_q;
  logic [6:0]       prev_sf_q;

  state_e           state_q, state_d;
  logic             ko_q, ko_d;
  logic [6:0]       seg_out_q, seg_out_d;
  logic             seg_valid_q, seg_valid_d;
  logic [CNT_W-1:0] wave_q, wave_d;
  logic             err_ill_q, err_ill_d;
  logic             err_tmo_q, err_tmo_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [6:0] bit_data;
  logic [6:0] bit_null;
  logic [6:0] bit_ill;
  logic       complete_data;
  logic       complete_null;
  logic       any_ill;
  logic       match;
  logic       cond;
  logic       accept;

  // Shift both rails through the synchronizer and track chain fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_sync_q <= '0;
      sf_sync_q <= '0;
      fill_q    <= '0;
      prev_st_q <= '0;
      prev_sf_q <= '0;
    end else begin
      st_sync_q <= {st_sync_q[SYNC_STAGES-2:0], seg_t};
      sf_sync_q <= {sf_sync_q[SYNC_STAGES-2:0], seg_f};
      fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_st_q <= st;
      prev_sf_q <= sf;
    end
  end

  assign st      = st_sync_q[SYNC_STAGES-1];
  assign sf      = sf_sync_q[SYNC_STAGES-1];
  assign sync_ok = fill_q[SYNC_STAGES-1];

  // Per-bit classification of the synchronized rails.
  always_comb begin
    bit_data      = st ^ sf;
    bit_null      = ~(st | sf);
    bit_ill       = st & sf;
    complete_data = sync_ok && (&bit_data);
    complete_null = sync_ok && (&bit_null);
    any_ill       = sync_ok && (|bit_ill);
    match         = (st == prev_st_q) && (sf == prev_sf_q);
  end

  // Next-state logic: stability run, acceptance, counters and sticky errors.
  always_comb begin
    state_d     = state_q;
    ko_d        = ko_q;
    seg_out_d   = seg_out_q;
    seg_valid_d = 1'b0;
    wave_d      = wave_q;
    err_ill_d   = err_ill_q | any_ill;
    err_tmo_d   = err_tmo_q | (tmo_q == TMO_W'(TIMEOUT - 1));
    run_d       = '0;
    accept      = 1'b0;
    cond        = (state_q == WAIT_DATA) ? complete_data : complete_null;

    // run_q counts cycles the current complete value has already been seen.
    // A new complete value starts the run at 1; an illegal bit or a partial
    // wavefront clears it.
    if (!any_ill && cond) begin
      accept = (run_q == RUN_W'(STABLE_CYCLES - 1)) && ((run_q == '0) || match);
      run_d  = match ? run_q + RUN_W'(1) : RUN_W'(1);
    end

    if (accept) begin
      run_d = '0;
      case (state_q)
        WAIT_DATA: begin
          seg_out_d   = st;
          seg_valid_d = 1'b1;
          wave_d      = wave_q + CNT_W'(1);
          ko_d        = 1'b0;
          state_d     = WAIT_NULL;
        end
        default: begin
          ko_d    = 1'b1;
          state_d = WAIT_DATA;
        end
      endcase
    end

    // Cycles since state entry, saturating at TIMEOUT.
    if (accept) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_W'(TIMEOUT)) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_NULL;
      ko_q        <= 1'b0;
      seg_out_q   <= '0;
      seg_valid_q <= 1'b0;
      wave_q      <= '0;
      err_ill_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      run_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      ko_q        <= ko_d;
      seg_out_q   <= seg_out_d;
      seg_valid_q <= seg_valid_d;
      wave_q      <= wave_d;
      err_ill_q   <= err_ill_d;
      err_tmo_q   <= err_tmo_d;
      run_q       <= run_d;
      tmo_q       <= tmo_d;
    end
  end

  assign ko          = ko_q;
  assign seg_out     = seg_out_q;
  assign seg_valid   = seg_valid_q;
  assign wave_count  = wave_q;
  assign err_illegal = err_ill_q;
  assign err_timeout = err_tmo_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ncl_seg_capture.sv
// Directed bench for ncl_seg_capture (TIMEOUT shortened to 16).
module tb_ncl_seg_capture;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       seg_t = 7'h00;
  logic [6:0]       seg_f = 7'h00;
  logic             ko;
  logic [6:0]       seg_out;
  logic             seg_valid;
  logic [CNT_W-1:0] wave_count;
  logic             err_illegal;
  logic             err_timeout;
  logic             dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_wave = 0;
  int pulses;

  // Clock
  always #5 clk = ~clk;

  ncl_seg_capture #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(2),
    .TIMEOUT      (16),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_t      (seg_t),
    .seg_f      (seg_f),
    .ko         (ko),
    .seg_out    (seg_out),
    .seg_valid  (seg_valid),
    .wave_count (wave_count),
    .err_illegal(err_illegal),
    .err_timeout(err_timeout),
    .dbg_state  (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] t, input logic [6:0] f);
    seg_t = t;
    seg_f = f;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ko"},      32'(ko), 32'd0);
    check({tag, "_seg_out"}, 32'(seg_out), 32'd0);
    check({tag, "_valid"},   32'(seg_valid), 32'd0);
    check({tag, "_wave"},    32'(wave_count), 32'd0);
    check({tag, "_ill"},     32'(err_illegal), 32'd0);
    check({tag, "_tmo"},     32'(err_timeout), 32'd0);
  endtask

  // Reset with NULL inputs, check cleared outputs, release after a negedge.
  task automatic do_reset();
    drive(7'h00, 7'h00);
    #2;
    rst_n = 1'b0;
    #3;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_wave = 0;
  endtask

  // Drive NULL: ko stays 0 through edge 3 and rises at edge 4.
  task automatic accept_null();
    drive(7'h00, 7'h00);
    tick(); tick(); tick();
    check("null_wait_ko", 32'(ko), 32'd0);
    check("null_wait_valid", 32'(seg_valid), 32'd0);
    tick();
    check("null_accept_ko", 32'(ko), 32'd1);
  endtask

  // Drive DATA: accepted on edge 4 with a single seg_valid pulse.
  task automatic accept_data(input logic [6:0] t, input logic [6:0] f, input logic [6:0] exp_seg);
    drive(t, f);
    tick(); tick(); tick();
    check("data_wait_ko", 32'(ko), 32'd1);
    check("data_wait_valid", 32'(seg_valid), 32'd0);
    tick();
    exp_wave = (exp_wave + 1) % 256;
    check("data_valid", 32'(seg_valid), 32'd1);
    check("data_seg_out", 32'(seg_out), 32'(exp_seg));
    check("data_wave", 32'(wave_count), 32'(exp_wave));
    check("data_ko", 32'(ko), 32'd0);
    tick();
    check("data_valid_drop", 32'(seg_valid), 32'd0);
  endtask

  // Directed sequence
  initial begin
    do_reset();
    accept_null();

    // Basic DATA/NULL cycle.
    accept_data(7'h3F, 7'h40, 7'h3F);
    // DATA held in WAIT_NULL is ignored.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(seg_valid);
    end
    check("ignore_pulses", 32'(pulses), 32'd0);
    check("ignore_ko", 32'(ko), 32'd0);
    check("ignore_ill", 32'(err_illegal), 32'd0);
    accept_null();

    // Partial wavefront never accepted.
    drive(7'h01, 7'h00);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += int'(seg_valid);
    end
    check("partial_pulses", 32'(pulses), 32'd0);
    check("partial_ko", 32'(ko), 32'd1);
    check("partial_timeout", 32'(err_timeout), 32'd1);
    accept_data(7'h01, 7'h7E, 7'h01);
    accept_null();

    // Skewed DATA: value changes one cycle after first complete.
    drive(7'h06, 7'h79);
    tick();
    drive(7'h5B, 7'h24);
    pulses = 0;
    tick(); pulses += int'(seg_valid);
    tick(); pulses += int'(seg_valid);
    tick(); pulses += int'(seg_valid);
    check("skew_early_valid", 32'(seg_valid), 32'd0);
    tick(); pulses += int'(seg_valid);
    exp_wave = (exp_wave + 1) % 256;
    check("skew_valid", 32'(seg_valid), 32'd1);
    check("skew_seg_out", 32'(seg_out), 32'h5B);
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(seg_valid);
    end
    check("skew_pulses", 32'(pulses), 32'd1);
    check("skew_wave", 32'(wave_count), 32'(exp_wave));
    accept_null();

    // Illegal bit 3 blocks acceptance and sets the sticky flag.
    drive(7'h0F, 7'h78);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(seg_valid);
    end
    check("illegal_flag", 32'(err_illegal), 32'd1);
    check("illegal_pulses", 32'(pulses), 32'd0);
    check("illegal_ko", 32'(ko), 32'd1);
    accept_data(7'h0F, 7'h70, 7'h0F);
    check("illegal_sticky", 32'(err_illegal), 32'd1);
    accept_null();

    // 256 DATA/NULL cycles: wave_count wraps, no timeout on short waits.
    do_reset();
    accept_null();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      accept_data(v[6:0], ~v[6:0], v[6:0]);
      if (i != 255) accept_null();
    end
    check("wrap_wave", 32'(wave_count), 32'd0);
    check("wrap_no_timeout", 32'(err_timeout), 32'd0);

    // Stall in WAIT_NULL: entered 1 edge ago; flag sets 16 edges after entry.
    for (int i = 0; i < 14; i++) tick();
    check("stall_before", 32'(err_timeout), 32'd0);
    tick();
    check("stall_timeout", 32'(err_timeout), 32'd1);
    check("stall_seg_out", 32'(seg_out), 32'h7F);

    // Asynchronous reset mid-WAIT_NULL clears everything at once.
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("midreset");

    // DATA arriving first after reset is ignored.
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pulses += int'(seg_valid);
    end
    check("data_first_ko", 32'(ko), 32'd0);
    check("data_first_pulses", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ncl_seg_capture.md
Name: ncl_seg_capture

Overview:
- Downstream sink for the dual-rail NCL 7-segment decoder.
- Brings the asynchronous dual-rail seg_t/seg_f wavefronts into the clock domain and detects DATA and NULL completion.
- Latches each DATA wavefront as a single-rail segment vector and returns the four-phase NCL acknowledge (ko) to the upstream stage.
- Feeds the synchronous display driver and flags protocol violations.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per rail (>=2).
- STABLE_CYCLES, 2, consecutive cycles a synchronized complete value must be identical before acceptance (>=1).
- TIMEOUT, 1024, cycles waiting in one state before err_timeout is set (>=2).
- CNT_W, 8, width of wave_count.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_t  input  7  true rails, bit 0 = segment a … bit 6 = segment g; asynchronous.
- seg_f  input  7  false rails; asynchronous.
- ko  output  1  acknowledge to upstream: 1 = request DATA, 0 = request NULL.
- seg_out  output  7  last accepted DATA value (single-rail, seg_t of the accepted wavefront).
- seg_valid  output  1  one-cycle pulse when seg_out updates.
- wave_count  output  CNT_W  number of accepted DATA wavefronts, wraps.
- err_illegal  output  1  sticky: a bit had both rails high.
- err_timeout  output  1  sticky: a completion wait exceeded TIMEOUT.

Behaviour:
- Clock and reset: single clock; reset is asynchronous, active-low (rst_n); all flops clear immediately on rst_n low.
- Reset values: state WAIT_NULL, ko=0, seg_out=0, seg_valid=0, wave_count=0, err_illegal=0, err_timeout=0, all sync flops 0, stability and timeout counters 0.
- Synchronization: each of the 14 rails passes through SYNC_STAGES flops. All decoding below uses the synchronized vectors st/sf.
- Per-bit classification: DATA if exactly one rail is high; NULL if both are low; ILLEGAL if both are high.
  - complete_data: all 7 bits DATA.
  - complete_null: all 7 bits NULL.
  - Otherwise the wavefront is partial.
- Stability counter:
  - Increments each cycle the target condition holds (complete_data in WAIT_DATA, complete_null in WAIT_NULL) and st/sf equal the previous cycle's values.
  - Clears otherwise.
  - Acceptance occurs on the edge where the condition holds and the counter equals STABLE_CYCLES-1.
  - Latency: accept on edge SYNC_STAGES+STABLE_CYCLES, counted from the first edge sampling a steady complete input (4 with defaults).
- State WAIT_DATA (ko=1): on acceptance, seg_out<=st, seg_valid<=1 for one cycle, wave_count<=wave_count+1 (wraps at 2^CNT_W to 0), ko<=0, next state WAIT_NULL.
- State WAIT_NULL (ko=0): on acceptance, ko<=1, next state WAIT_DATA; seg_out holds.
- The counter clears on every state transition.
- DATA present while in WAIT_NULL is ignored: no output change and no error.
- Illegal handling: any ILLEGAL bit in either state sets err_illegal (held until reset) and clears the stability counter. The state is unchanged.
- Timeout handling:
  - The timeout counter counts cycles since state entry and saturates.
  - Reaching TIMEOUT sets err_timeout (held until reset); waiting continues normally.
  - The counter clears on state transition.
- Simultaneous events: illegal detection has priority over acceptance in the same cycle (no acceptance). Timeout and acceptance in the same cycle both take effect.
- Reset mid-handshake: returns to WAIT_NULL with ko=0. The upstream stage must deliver NULL before any DATA is accepted; DATA arriving first is ignored.
- ko is registered and changes only on acceptance or reset.

Test Plan:
- Reset with inputs NULL, then release → ko=0 and no seg_valid.
  - Hold NULL → ko=1 at edge 4 after release.
- From WAIT_DATA, drive seg_t=7'h3F, seg_f=7'h40 → at edge 4: seg_out=7'h3F, one-cycle seg_valid, wave_count=1, ko=0.
  - Drive NULL → ko=1 after 4 edges.
- Partial wavefront: seg_t=7'h01, seg_f=7'h00 held for 20 cycles → no acceptance, ko stays 1.
  - Complete it to seg_t=7'h01, seg_f=7'h7E → accepted 4 edges later.
- Skewed data: change seg_t from 7'h06 to 7'h5B (seg_f the complement) one cycle after first complete → single acceptance with seg_out=7'h5B, no glitch pulse.
- Illegal: force seg_t[3]=seg_f[3]=1 with the other bits valid → err_illegal=1, no acceptance.
  - Fix the bit → accepted normally; err_illegal stays 1 until rst_n low.
- Run 256 DATA/NULL cycles (CNT_W=8) with TIMEOUT=16: wave_count wraps to 0, and a stall in WAIT_NULL sets err_timeout at cycle 16.
  - Then assert rst_n low mid-WAIT_NULL → all outputs cleared immediately.
